// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types for the fetch sequencer (FSM states, PC source).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_INC  = 3'd0,
        SEL_REL  = 3'd1,
        SEL_ABS  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4
    } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : Return-address LIFO, D bits wide, S entries deep.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int D = 12,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clr,
    input  logic [D-1:0] din,
    output logic [D-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int            CW      = $clog2(S + 1);
    localparam int            IW      = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] c_one   = CW'(1);
    localparam logic [CW-1:0] c_depth = CW'(S);

    logic [D-1:0]  r_mem [S];
    logic [CW-1:0] r_count;
    logic [IW-1:0] w_top_idx;

    // Top of stack is read combinationally so a pop returns its value the same cycle
    assign w_top_idx = IW'(r_count - c_one);
    assign dout      = r_mem[w_top_idx];
    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < S; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_mem[IW'(r_count)] <= din;
            r_count             <= r_count + c_one;
        end else if (pop && !empty) begin
            r_count <= r_count - c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_seq
//  Description : Run-controlled program counter with jump LUT and call stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int D         = 12,
    parameter int L         = 5,
    parameter int S         = 4,
    parameter int HALT_ADDR = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic         reljump_en,
    input  logic         absjump_en,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [L-1:0] lut_idx,
    input  logic [D-1:0] offset,
    input  logic         lut_wr_en,
    input  logic [L-1:0] lut_wr_idx,
    input  logic [D-1:0] lut_wr_data,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic         stack_err
);

    localparam int           c_lut_entries = 2 ** L;
    localparam logic [D-1:0] c_halt        = D'(HALT_ADDR);
    localparam logic [D-1:0] c_pc_one      = D'(1);

    state_t       r_state;
    logic [D-1:0] r_pc;
    logic         r_running;
    logic         r_done;
    logic         r_stack_err;
    logic [D-1:0] r_lut [c_lut_entries];

    pc_sel_t      w_sel;
    logic         w_stack_fault;
    logic [D-1:0] w_next_pc;
    logic [D-1:0] w_pc_inc;
    logic [D-1:0] w_lut_rd;
    logic [D-1:0] w_top;
    logic         w_active;
    logic         w_start;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;

    assign w_pc_inc = r_pc + c_pc_one;
    assign w_lut_rd = r_lut[lut_idx];
    assign w_active = (r_state == RUN) && !stall;
    assign w_start  = req && (r_state != RUN);
    assign w_push   = w_active && (w_sel == SEL_CALL);
    assign w_pop    = w_active && (w_sel == SEL_RET);

    // A ret on an empty stack or a call on a full one falls through to PC+1
    always_comb begin
        w_sel         = SEL_INC;
        w_stack_fault = 1'b0;
        if (ret_en) begin
            if (!w_empty) w_sel = SEL_RET;
            else          w_stack_fault = 1'b1;
        end else if (call_en) begin
            if (!w_full) w_sel = SEL_CALL;
            else         w_stack_fault = 1'b1;
        end else if (absjump_en) begin
            w_sel = SEL_ABS;
        end else if (reljump_en) begin
            w_sel = SEL_REL;
        end
    end

    always_comb begin
        w_next_pc = w_pc_inc;
        case (w_sel)
            SEL_RET:          w_next_pc = w_top;
            SEL_CALL, SEL_ABS: w_next_pc = w_lut_rd;
            SEL_REL:          w_next_pc = r_pc + offset;
            default:          w_next_pc = w_pc_inc;
        endcase
    end

    ret_stack #(
        .D (D),
        .S (S)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .clr   (w_start),
        .din   (w_pc_inc),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (req) begin
                        r_state     <= RUN;
                        r_pc        <= '0;
                        r_running   <= 1'b1;
                        r_done      <= 1'b0;
                        r_stack_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (w_stack_fault) r_stack_err <= 1'b1;
                        if (w_next_pc == c_halt) begin
                            r_state   <= DONE;
                            r_pc      <= c_halt;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pc      <= '0;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Writes land at the edge, so a same-cycle read still sees the old entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_lut_entries; i++) begin
                r_lut[i] <= '0;
            end
        end else if (lut_wr_en) begin
            r_lut[lut_wr_idx] <= lut_wr_data;
        end
    end

    assign prog_ctr  = r_pc;
    assign running   = r_running;
    assign done      = r_done;
    assign stack_err = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_seq
//  Description : Directed self-checking bench for fetch_seq (D=12 L=5 S=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

    logic        clk;
    logic        reset;
    logic        req;
    logic        stall;
    logic        reljump_en;
    logic        absjump_en;
    logic        call_en;
    logic        ret_en;
    logic [4:0]  lut_idx;
    logic [11:0] offset;
    logic        lut_wr_en;
    logic [4:0]  lut_wr_idx;
    logic [11:0] lut_wr_data;
    logic [11:0] prog_ctr;
    logic        running;
    logic        done;
    logic        stack_err;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_seq #(
        .D         (12),
        .L         (5),
        .S         (4),
        .HALT_ADDR (128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .stall       (stall),
        .reljump_en  (reljump_en),
        .absjump_en  (absjump_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .lut_idx     (lut_idx),
        .offset      (offset),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .prog_ctr    (prog_ctr),
        .running     (running),
        .done        (done),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        req = 0; stall = 0; reljump_en = 0; absjump_en = 0; call_en = 0; ret_en = 0;
        lut_idx = '0; offset = '0; lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
    endtask

    task automatic do_reset();
        clear_ctl();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic start_run();
        req = 1;
        tick();
        req = 0;
    endtask

    task automatic lut_write(input logic [4:0] idx, input logic [11:0] data);
        lut_wr_en = 1; lut_wr_idx = idx; lut_wr_data = data;
        tick();
        lut_wr_en = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({prog_ctr, running, done, stack_err} !== {12'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state: pc=%0d run=%b done=%b err=%b, want 0/0/0/0", prog_ctr, running, done, stack_err);
        end
        tick();
        n_cmp++;
        if ({prog_ctr, running} !== {12'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_hold: pc=%0d run=%b, want 0/0", prog_ctr, running);
        end
    endtask

    task automatic test_linear_run();
        do_reset();
        start_run();
        n_cmp++;
        if ({prog_ctr, running, done} !== {12'd0, 2'b10}) begin
            n_bad++;
            $display("FAIL run_entry: pc=%0d run=%b done=%b, want 0/1/0", prog_ctr, running, done);
        end
        for (int i = 1; i < 128; i++) begin
            tick();
            n_cmp++;
            if ({prog_ctr, running} !== {i[11:0], 1'b1}) begin
                n_bad++;
                $display("FAIL linear_pc: pc=%0d run=%b, want %0d/1", prog_ctr, running, i);
            end
        end
        tick();
        n_cmp++;
        if ({prog_ctr, running, done} !== {12'd128, 2'b01}) begin
            n_bad++;
            $display("FAIL halt: pc=%0d run=%b done=%b, want 128/0/1", prog_ctr, running, done);
        end
        absjump_en = 1; reljump_en = 1; call_en = 1; offset = 12'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({prog_ctr, running, done} !== {12'd128, 2'b01}) begin
                n_bad++;
                $display("FAIL done_hold: pc=%0d run=%b done=%b, want 128/0/1", prog_ctr, running, done);
            end
        end
        clear_ctl();
        start_run();
        n_cmp++;
        if ({prog_ctr, running, done} !== {12'd0, 2'b10}) begin
            n_bad++;
            $display("FAIL restart: pc=%0d run=%b done=%b, want 0/1/0", prog_ctr, running, done);
        end
        req = 1;
        tick();
        req = 0;
        n_cmp++;
        if (prog_ctr !== 12'd1) begin
            n_bad++;
            $display("FAIL req_in_run: pc=%0d, want 1", prog_ctr);
        end
    endtask

    task automatic test_lut_jumps();
        do_reset();
        lut_write(5'd3, 12'd40);
        lut_write(5'd1, 12'd4095);
        start_run();
        repeat (5) tick();
        n_cmp++;
        if (prog_ctr !== 12'd5) begin
            n_bad++;
            $display("FAIL pre_jump: pc=%0d, want 5", prog_ctr);
        end
        absjump_en = 1; lut_idx = 5'd3;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'd40) begin
            n_bad++;
            $display("FAIL abs_jump: pc=%0d, want 40", prog_ctr);
        end
        absjump_en = 0; reljump_en = 1; offset = 12'hFFE;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'd38) begin
            n_bad++;
            $display("FAIL rel_back: pc=%0d, want 38", prog_ctr);
        end
        reljump_en = 0; absjump_en = 1; lut_idx = 5'd1;
        tick();
        absjump_en = 0; reljump_en = 1; offset = 12'd1;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'd0) begin
            n_bad++;
            $display("FAIL rel_wrap: pc=%0d, want 0", prog_ctr);
        end
        reljump_en = 0; absjump_en = 1;
        tick();
        absjump_en = 0;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'd0) begin
            n_bad++;
            $display("FAIL inc_wrap: pc=%0d, want 0", prog_ctr);
        end
    endtask

    task automatic test_call_overflow();
        logic [11:0] exp_call [5] = '{12'd100, 12'd200, 12'd300, 12'd400, 12'd401};
        logic [4:0]  call_idx [5] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd4};
        logic [11:0] exp_ret  [5] = '{12'd301, 12'd201, 12'd101, 12'd1, 12'd2};
        do_reset();
        lut_write(5'd4, 12'd100);
        lut_write(5'd5, 12'd200);
        lut_write(5'd6, 12'd300);
        lut_write(5'd7, 12'd400);
        start_run();
        call_en = 1;
        for (int i = 0; i < 5; i++) begin
            lut_idx = call_idx[i];
            tick();
            n_cmp++;
            if ({prog_ctr, stack_err} !== {exp_call[i], (i == 4)}) begin
                n_bad++;
                $display("FAIL call_%0d: pc=%0d err=%b, want %0d/%b", i, prog_ctr, stack_err, exp_call[i], (i == 4));
            end
        end
        call_en = 0; ret_en = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({prog_ctr, stack_err} !== {exp_ret[i], 1'b1}) begin
                n_bad++;
                $display("FAIL ret_%0d: pc=%0d err=%b, want %0d/1", i, prog_ctr, stack_err, exp_ret[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        lut_write(5'd4, 12'd100);
        start_run();
        stall = 1; call_en = 1; lut_idx = 5'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({prog_ctr, running} !== {12'd0, 1'b1}) begin
                n_bad++;
                $display("FAIL stall_hold: pc=%0d run=%b, want 0/1", prog_ctr, running);
            end
        end
        stall = 0;
        tick();
        call_en = 0;
        n_cmp++;
        if (prog_ctr !== 12'd100) begin
            n_bad++;
            $display("FAIL stall_release: pc=%0d, want 100", prog_ctr);
        end
        ret_en = 1;
        tick();
        n_cmp++;
        if ({prog_ctr, stack_err} !== {12'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_ret: pc=%0d err=%b, want 1/0", prog_ctr, stack_err);
        end
        tick();
        n_cmp++;
        if ({prog_ctr, stack_err} !== {12'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_single_push: pc=%0d err=%b, want 2/1", prog_ctr, stack_err);
        end
    endtask

    task automatic test_priority();
        do_reset();
        lut_write(5'd9, 12'd16);
        lut_write(5'd10, 12'd500);
        lut_write(5'd11, 12'd600);
        start_run();
        absjump_en = 1; lut_idx = 5'd9;
        tick();
        absjump_en = 0; call_en = 1; lut_idx = 5'd10;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'd500) begin
            n_bad++;
            $display("FAIL prio_setup: pc=%0d, want 500", prog_ctr);
        end
        ret_en = 1; call_en = 1; absjump_en = 1; lut_idx = 5'd10;
        lut_wr_en = 1; lut_wr_idx = 5'd10; lut_wr_data = 12'd700;
        tick();
        clear_ctl();
        n_cmp++;
        if ({prog_ctr, stack_err} !== {12'd17, 1'b0}) begin
            n_bad++;
            $display("FAIL prio_ret: pc=%0d err=%b, want 17/0", prog_ctr, stack_err);
        end
        absjump_en = 1; lut_idx = 5'd11;
        lut_wr_en = 1; lut_wr_idx = 5'd11; lut_wr_data = 12'd900;
        tick();
        lut_wr_en = 0;
        n_cmp++;
        if (prog_ctr !== 12'd600) begin
            n_bad++;
            $display("FAIL lut_old_value: pc=%0d, want 600", prog_ctr);
        end
        tick();
        n_cmp++;
        if (prog_ctr !== 12'd900) begin
            n_bad++;
            $display("FAIL lut_new_value: pc=%0d, want 900", prog_ctr);
        end
        lut_idx = 5'd10;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'd700) begin
            n_bad++;
            $display("FAIL lut_wr_during_ret: pc=%0d, want 700", prog_ctr);
        end
        absjump_en = 0; ret_en = 1;
        tick();
        n_cmp++;
        if ({prog_ctr, stack_err} !== {12'd701, 1'b1}) begin
            n_bad++;
            $display("FAIL prio_no_push: pc=%0d err=%b, want 701/1", prog_ctr, stack_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lut_write(5'd12, 12'd57);
        lut_write(5'd3, 12'd40);
        start_run();
        ret_en = 1;
        tick();
        ret_en = 0; absjump_en = 1; lut_idx = 5'd12;
        tick();
        absjump_en = 0;
        n_cmp++;
        if ({prog_ctr, running, stack_err} !== {12'd57, 2'b11}) begin
            n_bad++;
            $display("FAIL pre_reset: pc=%0d run=%b err=%b, want 57/1/1", prog_ctr, running, stack_err);
        end
        #3;
        reset = 1;
        #1;
        n_cmp++;
        if ({prog_ctr, running, done, stack_err} !== {12'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL async_reset: pc=%0d run=%b done=%b err=%b, want 0/0/0/0", prog_ctr, running, done, stack_err);
        end
        tick();
        reset = 0;
        start_run();
        n_cmp++;
        if ({prog_ctr, running, stack_err} !== {12'd0, 2'b10}) begin
            n_bad++;
            $display("FAIL post_reset_run: pc=%0d run=%b err=%b, want 0/1/0", prog_ctr, running, stack_err);
        end
        absjump_en = 1; lut_idx = 5'd3;
        tick();
        absjump_en = 0;
        n_cmp++;
        if (prog_ctr !== 12'd0) begin
            n_bad++;
            $display("FAIL lut_cleared: pc=%0d, want 0", prog_ctr);
        end
    endtask

    initial begin
        clear_ctl();
        reset = 1;
        test_reset();
        test_linear_run();
        test_lut_jumps();
        test_call_overflow();
        test_stall();
        test_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Parametrised fetch sequencer; successor to the fixed-width PC + PC_LUT pair and the `prog_ctr == 128` done compare in the processor top level.
- Adds a req/done run handshake, stall, and a runtime-writable jump-target LUT.
- Adds a call/return stack with error flag.
- Drives prog_ctr to the instruction ROM. Control decoder supplies the jump/call/ret enables.

Parameters:
D, 12, program counter width (bits)
L, 5, jump LUT index width; LUT has 2**L entries of D bits
S, 4, return-stack depth (entries), S >= 1
HALT_ADDR, 128, PC value that terminates a run; must be < 2**D

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
req  input  1  start pulse; honoured in IDLE and DONE only
stall  input  1  hold PC and stack this cycle (RUN only)
reljump_en  input  1  PC <= PC + offset
absjump_en  input  1  PC <= lut[lut_idx]
call_en  input  1  push PC+1, PC <= lut[lut_idx]
ret_en  input  1  PC <= pop
lut_idx  input  L  LUT read index for abs jump / call
offset  input  D  two's-complement relative offset
lut_wr_en  input  1  LUT write strobe
lut_wr_idx  input  L  LUT write index
lut_wr_data  input  D  LUT write data
prog_ctr  output  D  current instruction address
running  output  1  high in RUN
done  output  1  high in DONE (registered)
stack_err  output  1  sticky: overflow or underflow since last req

Behaviour:
- Reset (async, any time, including mid-run) gives:
  - state IDLE; prog_ctr=0, running=0, done=0, stack_err=0.
  - stack empty; all LUT entries 0.
- FSM states: IDLE, RUN, DONE. All outputs are registered from state/PC; no combinational input-to-output paths.
- IDLE: req=1 -> RUN next cycle with prog_ctr=0 and stack_err=0. The stack is emptied on entry to RUN.
- RUN, stall=1: prog_ctr, stack and state hold. Jump/call/ret inputs are ignored.
- RUN, stall=0: next PC is chosen by strict priority ret > call > abs > rel > PC+1.
  - ret, stack non-empty: pop; PC <= popped value.
  - ret, stack empty: stack_err <= 1; PC <= PC+1.
  - call, stack not full: push PC+1; PC <= lut[lut_idx].
  - call, stack full (S entries): stack_err <= 1; no push; PC <= PC+1.
  - abs: PC <= lut[lut_idx].
  - rel: PC <= PC + offset, modulo 2**D (wraps both directions).
  - default: PC <= PC+1, modulo 2**D (2**D-1 wraps to 0).
- Halt: if the computed next PC == HALT_ADDR, then next cycle state=DONE, prog_ctr=HALT_ADDR, done=1, running=0.
  - A run can end via jump, call or ret landing on HALT_ADDR.
- DONE: prog_ctr and done hold; control inputs ignored. req=1 -> RUN next cycle with prog_ctr=0, done=0, stack emptied, stack_err=0.
- req in RUN: ignored.
- LUT:
  - Write accepted in any state; visible the cycle after lut_wr_en.
  - Same-cycle read of the written index returns the old value.
- Latency: every PC update is 1 cycle; done asserts in the same cycle prog_ctr first shows HALT_ADDR.

Decomposition:
- Package fetch_pkg:
  - state_t enum (IDLE, RUN, DONE).
  - pc_sel_t enum (SEL_INC, SEL_REL, SEL_ABS, SEL_CALL, SEL_RET).
- Sub-module ret_stack: parametrised LIFO of width D, depth S.
  - Ports: push, pop, clr, din, dout, full, empty.
  - Async reset.
  - Simultaneous push+pop cannot occur (priority logic guarantees).
- LUT is inline register array in fetch_seq.

Test Plan:
- Reset, req pulse, no jumps -> running=1, prog_ctr 0,1,2,...; done=1 with prog_ctr=128 exactly 128 cycles after entering RUN; holds until next req.
- Write lut[3]=40, abs jump idx 3 at PC=5 -> next PC=40. Rel offset=-2 (12'hFFE) at PC=40 -> 38. Rel from PC=4095 with offset 1 -> 0.
- S=4: five nested calls -> fifth sets stack_err=1, PC increments instead of jumping. Four rets return to the pushed PC+1 values in reverse order; a fifth ret -> PC+1, stack_err stays 1.
- stall held 3 cycles with call_en=1 -> prog_ctr and stack unchanged; after stall drops, call taken once.
- Simultaneous ret_en, call_en, absjump_en, stack holding 17 -> PC=17, no push. Same cycle lut_wr to lut_idx -> old value used.
- Assert reset mid-run at PC=57 between clock edges -> prog_ctr=0, running=0, state IDLE immediately. New req restarts from 0 with stack_err=0.
